// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
//   Shared helpers for the stream FIFO:
//   - cnt_width(depth) : bits needed to hold an occupancy of 0..depth
//   - ptr_width(depth) : bits needed to index 0..depth-1
//   - fifo_status_t    : packed bundle of the four status flags
package stream_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/stream_fifo_ctrl.sv
// stream_fifo_ctrl
//   Pointer, occupancy and peak-watermark bookkeeping for stream_fifo.
//   Ports:
//     clk, reset_n   clock / async active-low reset
//     flush          synchronous clear of pointers, count and peak
//     push, pop      already-qualified write / read strobes (push never when
//                    full, pop never when empty)
//     wr_ptr, rd_ptr circular-buffer write / read indices
//     count, peak    current and highest occupancy since reset/flush
//     status         full / empty / almost_full / almost_empty
module stream_fifo_ctrl
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int CW      = cnt_width(DEPTH),
  localparam int PW      = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic [CW-1:0] peak,
  output fifo_status_t  status
);

  logic [CW-1:0] count_next;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      peak   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      peak   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
      if (count_next > peak) peak <= count_next;
    end
  end

  always_comb begin
    status.full         = (count == CW'(DEPTH));
    status.empty        = (count == '0);
    status.almost_full  = (count >= CW'(AF_LEVEL));
    status.almost_empty = (count <= CW'(AE_LEVEL));
  end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo
//   Valid/ready streaming FIFO, first-word fall-through, DEPTH entries of
//   DATA_WIDTH bits, with occupancy count, peak watermark and status flags.
//   Optional macro STREAM_FIFO_BYPASS_EN: when empty, in_data is forwarded
//   combinationally to out_data; if consumed that cycle it is never stored.
//   Ports:
//     clk, reset_n                clock / async active-low reset
//     flush                       synchronous clear of contents and watermark
//     in_valid, in_data, in_ready write side handshake
//     out_valid, out_data, out_ready read side handshake
//     count, peak                 current / highest occupancy
//     full, empty, almost_full, almost_empty  status flags
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         peak,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  fifo_status_t          status;
  logic                  push;
  logic                  pop;
  logic                  fifo_push;
  logic                  fifo_pop;

  assign in_ready = ~status.full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

`ifdef STREAM_FIFO_BYPASS_EN
  // While empty the head is the incoming word itself; a pop in that state
  // consumes it directly, so neither storage nor pointers move.
  assign out_valid = ~status.empty | in_valid;
  assign out_data  = status.empty ? in_data : mem[rd_ptr];
  assign fifo_push = push & ~(status.empty & out_ready);
  assign fifo_pop  = pop & ~status.empty;
`else
  assign out_valid = ~status.empty;
  assign out_data  = mem[rd_ptr];
  assign fifo_push = push;
  assign fifo_pop  = pop;
`endif

  // Storage is cleared only by reset so out_data reads zero afterwards;
  // flush leaves stale contents behind, hidden by out_valid=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fifo_push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  stream_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .peak    (peak),
    .status  (status)
  );

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

endmodule
